// File: rtl/apb_seq_pkg.sv
// Shared types for the APB command sequencer: command layout and FSM states.
package apb_seq_pkg;

    localparam int DEF_AW = 4;
    localparam int DEF_DW = 8;

    typedef struct packed {
        logic              wr;
        logic [DEF_AW-1:0] addr;
        logic [DEF_DW-1:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/seq_cmd_fifo.sv
// Synchronous command FIFO; full/empty derived from an extra pointer wrap bit.
module seq_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    // Storage carries no reset; validity is tracked purely by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= wdata;
    end

endmodule

// File: rtl/apb_cmd_sequencer.sv
// Feeds queued host commands to the APB master one at a time and returns read data.
module apb_cmd_sequencer
    import apb_seq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_wr,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          newd,
    output logic          wr,
    output logic [AW-1:0] ain,
    output logic [DW-1:0] din,
    input  logic          apb_done,
    input  logic [DW-1:0] apb_rdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          busy,
    output logic          err_sticky
);

    localparam int EW  = 1 + AW + DW;
    localparam int WDW = $clog2(TIMEOUT);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    state_t         state;
    state_t         next_state;
    logic [WDW-1:0] wd;
    logic [WDW-1:0] wd_n;
    logic           full;
    logic           empty;
    logic           pop;
    logic [EW-1:0]  head;
    logic           head_wr;
    logic [AW-1:0]  head_addr;
    logic [DW-1:0]  head_wdata;

    logic           newd_n;
    logic           wr_n;
    logic [AW-1:0]  ain_n;
    logic [DW-1:0]  din_n;
    logic           rsp_valid_n;
    logic [DW-1:0]  rsp_rdata_n;
    logic           rsp_err_n;
    logic           err_sticky_n;

    seq_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .pop   (pop),
        .wdata ({cmd_wr, cmd_addr, cmd_wdata}),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    assign head_wr    = head[AW+DW];
    assign head_addr  = head[AW+DW-1:DW];
    assign head_wdata = head[DW-1:0];
    assign cmd_ready  = !full;
    assign busy       = (state != IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state   = state;
        pop          = 1'b0;
        wd_n         = wd;
        newd_n       = newd;
        wr_n         = wr;
        ain_n        = ain;
        din_n        = din;
        rsp_valid_n  = rsp_valid;
        rsp_rdata_n  = rsp_rdata;
        rsp_err_n    = rsp_err;
        err_sticky_n = err_sticky;
        case (state)
            IDLE: begin
                if (!empty) begin
                    newd_n     = 1'b1;
                    wr_n       = head_wr;
                    ain_n      = head_addr;
                    din_n      = head_wr ? head_wdata : '0;
                    wd_n       = '0;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                wd_n = wd + WDW'(1);
                // Completion wins over the watchdog when both land on the same cycle.
                if (apb_done || (wd == WD_LAST)) begin
                    pop    = 1'b1;
                    newd_n = 1'b0;
                    if (!apb_done) err_sticky_n = 1'b1;
                    if (wr) begin
                        next_state = IDLE;
                    end else begin
                        rsp_valid_n = 1'b1;
                        rsp_rdata_n = apb_done ? apb_rdata : '0;
                        rsp_err_n   = !apb_done;
                        next_state  = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    next_state  = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd         <= '0;
            newd       <= 1'b0;
            wr         <= 1'b0;
            ain        <= '0;
            din        <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            wd         <= wd_n;
            newd       <= newd_n;
            wr         <= wr_n;
            ain        <= ain_n;
            din        <= din_n;
            rsp_valid  <= rsp_valid_n;
            rsp_rdata  <= rsp_rdata_n;
            rsp_err    <= rsp_err_n;
            err_sticky <= err_sticky_n;
        end
    end

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// Directed self-checking bench for apb_cmd_sequencer.
module tb_apb_cmd_sequencer;
    import apb_seq_pkg::*;

    localparam int DEPTH   = 4;
    localparam int AW      = 4;
    localparam int DW      = 8;
    localparam int TIMEOUT = 16;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_wr;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          newd;
    logic          wr;
    logic [AW-1:0] ain;
    logic [DW-1:0] din;
    logic          apb_done;
    logic [DW-1:0] apb_rdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          busy;
    logic          err_sticky;

    int   checks = 0;
    int   errors = 0;
    int   n_high;
    int   pi;
    int   issued;
    int   rn;
    int   run;
    int   max_run;
    logic prev_newd;
    logic will_push;
    cmd_t c;
    cmd_t t6 [20];
    logic [7:0] exp_rd [10];

    apb_cmd_sequencer #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_wr     (cmd_wr),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .newd       (newd),
        .wr         (wr),
        .ain        (ain),
        .din        (din),
        .apb_done   (apb_done),
        .apb_rdata  (apb_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .err_sticky (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "[TB] simulation did not terminate");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic v, input cmd_t cmd);
        cmd_valid = v;
        cmd_wr    = cmd.wr;
        cmd_addr  = cmd.addr;
        cmd_wdata = cmd.wdata;
    endtask

    task automatic push(input cmd_t cmd);
        apply_stimulus(1'b1, cmd);
        tick();
        apply_stimulus(1'b0, cmd);
    endtask

    function automatic logic [7:0] rd_pattern(input logic [3:0] a);
        return {a, ~a};
    endfunction

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        apb_done  = 1'b0;
        apb_rdata = '0;
        rsp_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check_output("rst_newd", 32'(newd), 0);
        check_output("rst_rsp_valid", 32'(rsp_valid), 0);
        check_output("rst_err_sticky", 32'(err_sticky), 0);
        check_output("rst_busy", 32'(busy), 0);
        check_output("rst_cmd_ready", 32'(cmd_ready), 1);
        rst = 1'b0;
        tick();

        // Test 1: single write
        c = '{wr: 1'b1, addr: 4'h3, wdata: 8'hA5};
        push(c);
        check_output("t1_newd_pre", 32'(newd), 0);
        check_output("t1_busy_queued", 32'(busy), 1);
        tick();
        check_output("t1_newd", 32'(newd), 1);
        check_output("t1_wr", 32'(wr), 1);
        check_output("t1_ain", 32'(ain), 'h3);
        check_output("t1_din", 32'(din), 'hA5);
        tick();
        check_output("t1_newd_hold", 32'(newd), 1);
        check_output("t1_ain_hold", 32'(ain), 'h3);
        apb_done = 1'b1;
        tick();
        apb_done = 1'b0;
        check_output("t1_newd_drop", 32'(newd), 0);
        check_output("t1_rsp_valid", 32'(rsp_valid), 0);
        check_output("t1_busy_end", 32'(busy), 0);

        // Test 2: write then read back with response backpressure
        c = '{wr: 1'b1, addr: 4'h6, wdata: 8'h5C};
        push(c);
        c = '{wr: 1'b0, addr: 4'h6, wdata: 8'hFF};
        push(c);
        check_output("t2_w_newd", 32'(newd), 1);
        check_output("t2_w_wr", 32'(wr), 1);
        check_output("t2_w_ain", 32'(ain), 'h6);
        check_output("t2_w_din", 32'(din), 'h5C);
        apb_done = 1'b1;
        tick();
        apb_done = 1'b0;
        check_output("t2_gap_newd", 32'(newd), 0);
        tick();
        check_output("t2_r_newd", 32'(newd), 1);
        check_output("t2_r_wr", 32'(wr), 0);
        check_output("t2_r_ain", 32'(ain), 'h6);
        check_output("t2_r_din", 32'(din), 0);
        apb_done  = 1'b1;
        apb_rdata = 8'h5C;
        tick();
        apb_done  = 1'b0;
        apb_rdata = 8'h00;
        check_output("t2_rsp_valid", 32'(rsp_valid), 1);
        check_output("t2_rsp_rdata", 32'(rsp_rdata), 'h5C);
        check_output("t2_rsp_err", 32'(rsp_err), 0);
        check_output("t2_newd_low", 32'(newd), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("t2_rsp_hold_valid", 32'(rsp_valid), 1);
            check_output("t2_rsp_hold_rdata", 32'(rsp_rdata), 'h5C);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_output("t2_rsp_drop", 32'(rsp_valid), 0);
        check_output("t2_busy_end", 32'(busy), 0);

        // Test 3: overfill the queue
        for (int k = 0; k < 5; k++) begin
            c = '{wr: 1'b1, addr: 4'(8 + k), wdata: 8'(8'h10 + k)};
            apply_stimulus(1'b1, c);
            tick();
            if (k == 2) check_output("t3_ready_3", 32'(cmd_ready), 1);
            if (k >= 3) check_output("t3_ready_full", 32'(cmd_ready), 0);
        end
        apply_stimulus(1'b0, c);
        check_output("t3_head_newd", 32'(newd), 1);
        check_output("t3_head_ain", 32'(ain), 'h8);
        check_output("t3_head_din", 32'(din), 'h10);
        apb_done = 1'b1;
        tick();
        apb_done = 1'b0;
        check_output("t3_ready_after_pop", 32'(cmd_ready), 1);
        for (int k = 1; k < 4; k++) begin
            tick();
            check_output("t3_order_newd", 32'(newd), 1);
            check_output("t3_order_ain", 32'(ain), 32'(8 + k));
            check_output("t3_order_din", 32'(din), 32'(8'h10 + k));
            apb_done = 1'b1;
            tick();
            apb_done = 1'b0;
            check_output("t3_order_drop", 32'(newd), 0);
        end
        check_output("t3_fifth_dropped", 32'(busy), 0);

        // Test 4: read timeout, followed by a queued write
        c = '{wr: 1'b0, addr: 4'hA, wdata: 8'h00};
        push(c);
        c = '{wr: 1'b1, addr: 4'hB, wdata: 8'h77};
        push(c);
        apb_rdata = 8'h3C;
        n_high = 0;
        for (int i = 0; i < 40 && newd; i++) begin
            n_high++;
            tick();
        end
        check_output("t4_newd_cycles", 32'(n_high), 16);
        check_output("t4_rsp_valid", 32'(rsp_valid), 1);
        check_output("t4_rsp_rdata", 32'(rsp_rdata), 0);
        check_output("t4_rsp_err", 32'(rsp_err), 1);
        check_output("t4_err_sticky", 32'(err_sticky), 1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        apb_rdata = 8'h00;
        check_output("t4_rsp_drop", 32'(rsp_valid), 0);
        tick();
        check_output("t4_next_newd", 32'(newd), 1);
        check_output("t4_next_wr", 32'(wr), 1);
        check_output("t4_next_ain", 32'(ain), 'hB);
        check_output("t4_next_din", 32'(din), 'h77);
        apb_done = 1'b1;
        tick();
        apb_done = 1'b0;
        check_output("t4_next_done", 32'(newd), 0);
        check_output("t4_no_rsp_write", 32'(rsp_valid), 0);
        check_output("t4_sticky_kept", 32'(err_sticky), 1);

        // Test 5: reset while waiting with entries queued
        for (int k = 0; k < 3; k++) begin
            c = '{wr: 1'b0, addr: 4'(k + 1), wdata: 8'h00};
            push(c);
        end
        check_output("t5_inflight", 32'(newd), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("t5_newd", 32'(newd), 0);
        check_output("t5_cmd_ready", 32'(cmd_ready), 1);
        check_output("t5_busy", 32'(busy), 0);
        check_output("t5_err_sticky", 32'(err_sticky), 0);
        apb_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("t5_quiet_newd", 32'(newd), 0);
            check_output("t5_quiet_rsp", 32'(rsp_valid), 0);
        end
        apb_done = 1'b0;

        // Test 6: apb_done held high across 10 writes then 10 reads
        for (int k = 0; k < 20; k++) begin
            t6[k].wr    = (k < 10);
            t6[k].addr  = 4'($urandom_range(0, 15));
            t6[k].wdata = 8'($urandom_range(0, 255));
        end
        for (int k = 0; k < 10; k++) exp_rd[k] = rd_pattern(t6[10 + k].addr);
        pi        = 0;
        issued    = 0;
        rn        = 0;
        run       = 0;
        max_run   = 0;
        prev_newd = 1'b0;
        apb_done  = 1'b1;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (newd && !prev_newd) begin
                if (issued < 20) begin
                    check_output("t6_wr", 32'(wr), 32'(t6[issued].wr));
                    check_output("t6_ain", 32'(ain), 32'(t6[issued].addr));
                    check_output("t6_din", 32'(din), t6[issued].wr ? 32'(t6[issued].wdata) : 0);
                end
                issued++;
            end
            run = newd ? run + 1 : 0;
            if (run > max_run) max_run = run;
            if (rsp_valid) begin
                if (rn < 10) check_output("t6_rsp_rdata", 32'(rsp_rdata), 32'(exp_rd[rn]));
                check_output("t6_rsp_err", 32'(rsp_err), 0);
                rn++;
            end
            prev_newd = newd;
            if (issued == 20 && rn == 10 && !busy) break;
            apb_rdata = rd_pattern(ain);
            if (pi < 20) apply_stimulus(1'b1, t6[pi]);
            else         apply_stimulus(1'b0, t6[0]);
            will_push = cmd_valid && cmd_ready;
            tick();
            if (will_push) pi++;
        end
        apply_stimulus(1'b0, t6[0]);
        apb_done  = 1'b0;
        rsp_ready = 1'b0;
        check_output("t6_issued", 32'(issued), 20);
        check_output("t6_responses", 32'(rn), 10);
        check_output("t6_newd_max_run", 32'(max_run), 1);
        check_output("t6_busy_end", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
